// File: rtl/spi_dac_rx_2ch_if.sv
// spi_dac_rx_2ch_if -- bundle of SPI pins and DAC-code outputs for spi_dac_rx_2ch.
//   sclk_i, cs_ni, mosi_i   : SPI mode-0 pins, driven by the master side
//   ch0_data_o, ch1_data_o  : last valid code per channel
//   ch0_upd_o, ch1_upd_o    : one-cycle update pulses
//   eod_o                   : one-cycle pulse, ch0 frame directly followed by ch1 frame
//   frame_err_o             : one-cycle pulse, frame discarded
//   busy_o                  : frame reception in progress
interface spi_dac_rx_2ch_if #(
   parameter int DATA_W = 12
);
   logic              sclk_i;
   logic              cs_ni;
   logic              mosi_i;
   logic [DATA_W-1:0] ch0_data_o;
   logic [DATA_W-1:0] ch1_data_o;
   logic              ch0_upd_o;
   logic              ch1_upd_o;
   logic              eod_o;
   logic              frame_err_o;
   logic              busy_o;

   modport master (
      output sclk_i, cs_ni, mosi_i,
      input  ch0_data_o, ch1_data_o, ch0_upd_o, ch1_upd_o, eod_o, frame_err_o, busy_o
   );

   modport slave (
      input  sclk_i, cs_ni, mosi_i,
      output ch0_data_o, ch1_data_o, ch0_upd_o, ch1_upd_o, eod_o, frame_err_o, busy_o
   );
endinterface

// File: rtl/spi_dac_rx_2ch.sv
// spi_dac_rx_2ch -- SPI mode-0 slave receiving two-channel DAC codes.
// A frame of FRAME_BITS bits (MSB first) carries the channel select in its MSB
// and the code in bits [DATA_W-1:0]. Frames of the wrong length are discarded.
//   clk_i  : system clock (rising edge only)
//   rst_ni : asynchronous active-low reset
//   bus    : spi_dac_rx_2ch_if.slave (SPI pins in, codes/pulses/busy out)
//
// Frame FSM
//   state     | meaning
//   WAIT_IDLE | after reset, wait for cs_n genuinely high before accepting frames
//   IDLE      | wait for cs_n falling edge
//   SHIFT     | shift mosi on sclk rising edges, count bits
//   CHECK     | one cycle: judge frame length, hand result to output stage
//
// Pair tracker
//   state     | meaning
//   WAIT_CH0  | no pending ch0 frame
//   WAIT_CH1  | last valid frame was ch0; a ch1 frame now completes the pair
module spi_dac_rx_2ch #(
   parameter int FRAME_BITS = 16,
   parameter int DATA_W     = 12
) (
   input logic             clk_i,
   input logic             rst_ni,
   spi_dac_rx_2ch_if.slave bus
);

   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, CHECK} frame_state_t;
   typedef enum logic {WAIT_CH0, WAIT_CH1} pair_state_t;

   // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection
   logic [2:0] sclk_s;
   logic [2:0] cs_s;
   logic [1:0] mosi_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_s <= 3'b000;
         cs_s   <= 3'b111;
         mosi_s <= 2'b00;
      end else begin
         sclk_s <= {sclk_s[1:0], bus.sclk_i};
         cs_s   <= {cs_s[1:0], bus.cs_ni};
         mosi_s <= {mosi_s[0], bus.mosi_i};
      end
   end

   logic sclk_rise, cs_rise, cs_fall;
   assign sclk_rise = sclk_s[1] & ~sclk_s[2];
   assign cs_rise   = cs_s[1] & ~cs_s[2];
   assign cs_fall   = ~cs_s[1] & cs_s[2];

   frame_state_t          state;
   logic [CW-1:0]         cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic                  busy;
   logic [1:0]            settle;
   logic                  res_valid, res_err, res_ch;
   logic [DATA_W-1:0]     res_data;

   // The cs_n synchronizer resets to "high", so right after reset it does not yet
   // reflect the pin. The settle timer holds WAIT_IDLE until the reset value has
   // been flushed, so a cs_n still low from an aborted frame is not mistaken for idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= WAIT_IDLE;
         cnt       <= '0;
         shreg     <= '0;
         busy      <= 1'b0;
         settle    <= 2'd3;
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         res_ch    <= 1'b0;
         res_data  <= '0;
      end else begin
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         if (settle != 2'd0) settle <= settle - 2'd1;
         case (state)
            WAIT_IDLE: begin
               if (settle == 2'd0 && cs_s[1]) state <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  shreg <= '0;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state <= CHECK;
                  busy  <= 1'b0;
               end else if (sclk_rise) begin
                  shreg <= {shreg[FRAME_BITS-2:0], mosi_s[1]};
                  if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
               end
            end
            CHECK: begin
               state    <= IDLE;
               res_ch   <= shreg[FRAME_BITS-1];
               res_data <= shreg[DATA_W-1:0];
               if (cnt == CNT_FULL) res_valid <= 1'b1;
               else                 res_err   <= 1'b1;
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

   pair_state_t       pair;
   logic [DATA_W-1:0] ch0_q, ch1_q;
   logic              upd0_q, upd1_q, eod_q, err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pair   <= WAIT_CH0;
         ch0_q  <= '0;
         ch1_q  <= '0;
         upd0_q <= 1'b0;
         upd1_q <= 1'b0;
         eod_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         upd0_q <= 1'b0;
         upd1_q <= 1'b0;
         eod_q  <= 1'b0;
         err_q  <= 1'b0;
         if (res_valid && !res_ch) begin
            ch0_q  <= res_data;
            upd0_q <= 1'b1;
            pair   <= WAIT_CH1;
         end else if (res_valid && res_ch) begin
            ch1_q  <= res_data;
            upd1_q <= 1'b1;
            eod_q  <= (pair == WAIT_CH1);
            pair   <= WAIT_CH0;
         end else if (res_err) begin
            err_q <= 1'b1;
            pair  <= WAIT_CH0;
         end
      end
   end

   assign bus.ch0_data_o  = ch0_q;
   assign bus.ch1_data_o  = ch1_q;
   assign bus.ch0_upd_o   = upd0_q;
   assign bus.ch1_upd_o   = upd1_q;
   assign bus.eod_o       = eod_q;
   assign bus.frame_err_o = err_q;
   assign bus.busy_o      = busy;

endmodule

// File: tb/tb_spi_dac_rx_2ch.sv
// tb_spi_dac_rx_2ch -- scoreboard bench for spi_dac_rx_2ch.
// Stimulus drives SPI frames and pushes the expected output event; a monitor
// pops and compares whenever the DUT pulses an update or error.
module tb_spi_dac_rx_2ch;

   localparam int HALF = 50;   // sclk half period (clk period 10)
   localparam int GAP  = 300;  // cs_n high time between frames

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_dac_rx_2ch_if #(.DATA_W(12)) bus ();

   spi_dac_rx_2ch #(.FRAME_BITS(16), .DATA_W(12)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      int         kind;   // 0 = ch0 update, 1 = ch1 update, 2 = frame error
      logic [11:0] c0;
      logic [11:0] c1;
      logic        eod;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [11:0] m_ch0 = '0;
   logic [11:0] m_ch1 = '0;
   logic        m_pair = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_valid(input logic [15:0] frame);
      exp_t e;
      if (frame[15] == 1'b0) begin
         m_ch0  = frame[11:0];
         e.kind = 0;
         e.eod  = 1'b0;
         m_pair = 1'b1;
      end else begin
         m_ch1  = frame[11:0];
         e.kind = 1;
         e.eod  = m_pair;
         m_pair = 1'b0;
      end
      e.c0 = m_ch0;
      e.c1 = m_ch1;
      q.push_back(e);
   endtask

   task automatic expect_err();
      exp_t e;
      m_pair = 1'b0;
      e.kind = 2;
      e.c0   = m_ch0;
      e.c1   = m_ch1;
      e.eod  = 1'b0;
      q.push_back(e);
   endtask

   task automatic spi_bit(input logic b);
      bus.mosi_i = b;
      #HALF;
      bus.sclk_i = 1'b1;
      #HALF;
      bus.sclk_i = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] frame, input int nbits, input bit timed);
      logic pulse;
      bus.cs_ni = 1'b0;
      #HALF;
      for (int i = nbits - 1; i >= 0; i--) spi_bit(frame[i]);
      #HALF;
      if (timed) begin
         check("busy_in_shift", 32'(bus.busy_o), 1);
         @(posedge clk);
         #2;
         bus.cs_ni = 1'b1;
         // edge 0 samples cs_n high; update must appear on edge 4
         for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            #1;
            pulse = bus.ch0_upd_o | bus.ch1_upd_o | bus.frame_err_o;
            if (k == 1) check("busy_until_check", 32'(bus.busy_o), 1);
            if (k == 2) check("busy_low_in_check", 32'(bus.busy_o), 0);
            check($sformatf("latency_edge%0d", k), 32'(pulse), (k == 4) ? 32'd1 : 32'd0);
         end
      end else begin
         bus.cs_ni = 1'b1;
      end
      #GAP;
   endtask

   // monitor
   always @(negedge clk) begin
      exp_t e;
      int   kind;
      int   npulse;
      if (rst_n) begin
         npulse = int'(bus.ch0_upd_o) + int'(bus.ch1_upd_o) + int'(bus.frame_err_o);
         if (bus.eod_o) check("eod_with_ch1_upd", 32'(bus.ch1_upd_o), 1);
         if (npulse != 0) begin
            check("pulses_exclusive", 32'(npulse), 1);
            kind = bus.ch0_upd_o ? 0 : (bus.ch1_upd_o ? 1 : 2);
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pulse: got kind %0d, expected no pulse at %0t", kind, $time);
            end else begin
               e = q.pop_front();
               check("event_kind", 32'(kind), 32'(e.kind));
               check("ch0_data", 32'(bus.ch0_data_o), 32'(e.c0));
               check("ch1_data", 32'(bus.ch1_data_o), 32'(e.c1));
               check("eod", 32'(bus.eod_o), 32'(e.eod));
            end
         end
      end
   end

   initial begin
      bus.sclk_i = 1'b0;
      bus.cs_ni  = 1'b1;
      bus.mosi_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ch0_data", 32'(bus.ch0_data_o), 0);
      check("rst_ch1_data", 32'(bus.ch1_data_o), 0);
      check("rst_ch0_upd", 32'(bus.ch0_upd_o), 0);
      check("rst_ch1_upd", 32'(bus.ch1_upd_o), 0);
      check("rst_eod", 32'(bus.eod_o), 0);
      check("rst_frame_err", 32'(bus.frame_err_o), 0);
      check("rst_busy", 32'(bus.busy_o), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);

      // ch0 then ch1: pair completes
      expect_valid(16'h0ABC); send_frame(32'h0ABC, 16, 1'b1);
      expect_valid(16'h8123); send_frame(32'h8123, 16, 1'b0);

      // errors reset the tracker
      expect_valid(16'h0777); send_frame(32'h0777, 16, 1'b0);
      expect_err();           send_frame(32'h1234, 15, 1'b0);
      expect_err();           send_frame(32'h1ABCD, 17, 1'b0);
      expect_valid(16'h8456); send_frame(32'h8456, 16, 1'b0);

      // lone ch1
      expect_valid(16'h8FFF); send_frame(32'h8FFF, 16, 1'b0);

      // repeated ch0 before ch1
      expect_valid(16'h0001); send_frame(32'h0001, 16, 1'b0);
      expect_valid(16'h0002); send_frame(32'h0002, 16, 1'b0);
      expect_valid(16'h8003); send_frame(32'h8003, 16, 1'b0);

      // bits above the code field are ignored
      expect_valid(16'h7ABC); send_frame(32'h7ABC, 16, 1'b0);

      // reset in the middle of a frame, cs_n kept low through the rest
      bus.cs_ni = 1'b0;
      #HALF;
      for (int i = 15; i >= 8; i--) spi_bit(1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_ch0_data", 32'(bus.ch0_data_o), 0);
      check("midrst_ch1_data", 32'(bus.ch1_data_o), 0);
      check("midrst_busy", 32'(bus.busy_o), 0);
      m_ch0  = '0;
      m_ch1  = '0;
      m_pair = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 7; i >= 0; i--) spi_bit(1'b0);
      #HALF;
      bus.cs_ni = 1'b1;
      #GAP;
      check("after_abort_busy", 32'(bus.busy_o), 0);

      expect_valid(16'h0555); send_frame(32'h0555, 16, 1'b1);
      expect_valid(16'h8AAA); send_frame(32'h8AAA, 16, 1'b0);

      for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
      check("queue_drained", 32'(q.size()), 0);
      check("final_busy", 32'(bus.busy_o), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_dac_rx_2ch.md
SPI_DAC_RX_2CH -- requirements
Module: spi_dac_rx_2ch

Interface
REQ-001 Parameter FRAME_BITS, default 16: SPI frame length in bits.
REQ-002 Parameter DATA_W, default 12: DAC code width, taken from frame bits [DATA_W-1:0].
REQ-003 clk_i  input  1  system clock; all logic SHALL use its rising edge; one clock only.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 sclk_i  input  1  SPI serial clock, asynchronous to clk_i, mode 0.
REQ-006 cs_ni  input  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi_i  input  1  SPI serial data, MSB first, asynchronous.
REQ-008 ch0_data_o  output  DATA_W  last valid channel-0 code.
REQ-009 ch1_data_o  output  DATA_W  last valid channel-1 code.
REQ-010 ch0_upd_o  output  1  one-cycle pulse when ch0_data_o is updated.
REQ-011 ch1_upd_o  output  1  one-cycle pulse when ch1_data_o is updated.
REQ-012 eod_o  output  1  one-cycle pulse when a ch0 frame is followed directly by a ch1 frame.
REQ-013 frame_err_o  output  1  one-cycle pulse when a frame is discarded.
REQ-014 busy_o  output  1  high while a frame is being received (state SHIFT).

Function
REQ-015 sclk_i, cs_ni and mosi_i SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on synchronized values against a third registered copy.
REQ-016 Frame FSM states: WAIT_IDLE, IDLE, SHIFT, CHECK.
REQ-017 WAIT_IDLE -> IDLE when synchronized cs_n is high; no shifting in WAIT_IDLE.
REQ-018 IDLE -> SHIFT on synchronized cs_n falling edge; bit counter and shift register SHALL clear.
REQ-019 In SHIFT, each synchronized sclk rising edge SHALL shift in synchronized mosi (MSB first) and increment the bit counter, saturating at FRAME_BITS+1.
REQ-020 SHIFT -> CHECK on synchronized cs_n rising edge; sclk edges in the same cycle SHALL be ignored.
REQ-021 CHECK -> IDLE after exactly one cycle.
REQ-022 In CHECK, with count == FRAME_BITS: frame bit [FRAME_BITS-1] selects channel (0 = ch0, 1 = ch1); the addressed chN_data_o SHALL load bits [DATA_W-1:0] and chN_upd_o SHALL pulse in the following cycle.
REQ-023 In CHECK, with count != FRAME_BITS (short or long): no data register SHALL change; frame_err_o SHALL pulse in the following cycle.
REQ-024 Latency: outputs SHALL update on the 4th clk_i rising edge after the first edge that samples cs_ni high.
REQ-025 Pair tracker states: WAIT_CH0, WAIT_CH1.
REQ-026 WAIT_CH0 + valid ch0 frame -> WAIT_CH1; valid ch1 frame -> update ch1, stay in WAIT_CH0, no eod_o.
REQ-027 WAIT_CH1 + valid ch1 frame -> eod_o pulses in the same cycle as ch1_upd_o, -> WAIT_CH0.
REQ-028 WAIT_CH1 + valid ch0 frame -> update ch0, remain WAIT_CH1.
REQ-029 Any error frame -> WAIT_CH0.
REQ-030 ch0_upd_o, ch1_upd_o and frame_err_o SHALL be mutually exclusive; at most one pulse per frame.
REQ-031 Correct operation requires clk_i >= 8x sclk_i frequency and cs_ni high for >= 4 clk_i cycles between frames; behaviour outside these limits is undefined but SHALL NOT lock up the FSMs.

Reset
REQ-032 With rst_ni low: ch0_data_o = 0, ch1_data_o = 0, all pulse outputs = 0, busy_o = 0, frame FSM = WAIT_IDLE, pair tracker = WAIT_CH0, synchronizers = 1 for cs_n, 0 for sclk/mosi.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no update and no error pulse; after release, a still-low cs_ni SHALL be ignored until it rises (WAIT_IDLE).

Verification
REQ-034 Frame 0x0ABC, then frame 0x8123 -> ch0_data_o = 0xABC with ch0_upd_o pulse; then ch1_data_o = 0x123 with ch1_upd_o and eod_o pulses in the same cycle.
REQ-035 15-bit frame, then 17-bit frame -> two frame_err_o pulses; data unchanged; tracker returns to WAIT_CH0 (next ch1 frame gives no eod_o).
REQ-036 ch1 frame 0x8FFF alone -> ch1_data_o = 0xFFF, ch1_upd_o pulse, no eod_o.
REQ-037 Two ch0 frames (0x0001, 0x0002), then ch1 frame 0x8003 -> ch0_data_o = 0x002; eod_o pulses once, with the ch1 update.
REQ-038 rst_ni pulsed low after 8 bits of a frame, cs_ni held low through the rest of the frame -> no updates or errors; next full frame is received correctly.
REQ-039 Timing check: cs_ni rises -> update pulse on exactly the 4th clk_i edge; busy_o high from SHIFT entry until CHECK.
